spi_write_sequencer: RTL and testbench

Master-side SPI write sequencer that turns parallel register-write requests into 16-bit SPI write frames for the chip's SPI configuration port. It accepts one (address, data) request at a time over a valid/ready handshake, validates the address, and serializes the frame on SCLK/COPI/nCS in mode 0, MSB first. It sits between on-chip configuration logic (boot script, test controller) and the configuration register file, and is the only driver of the SPI pins.

---
 rtl/spi_cfg_pkg.sv | 38 +++
 rtl/spi_phase_timer.sv | 32 +++
 rtl/spi_write_sequencer.sv | 173 +++++++++++++++++
 tb/tb_spi_write_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cfg_pkg                                                                |
// | Frame geometry, register map and FSM states for the SPI write sequencer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package spi_cfg_pkg;

  localparam int FRAME_W   = 16;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int WRITE_BIT = 15;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] PWM_EN_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] PWM_EN_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'd4;

  localparam logic [ADDR_W-1:0] MAX_ADDR_DEFAULT = PWM_DUTY;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {1'b1, addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_phase_timer                                                            |
// | Loadable down-counter; o_tick is high while the count sits at zero.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_write_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_write_sequencer                                                        |
// | Turns (addr, data) write requests into mode-0, MSB-first 16-bit SPI frames.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_write_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int                CLK_DIV  = 4,
  parameter int                NCS_GAP  = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              copi,
  output logic              ncs
);

  localparam int CNT_MAX = (CLK_DIV > NCS_GAP) ? CLK_DIV : NCS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD = CNT_W'(NCS_GAP - 1);

  state_t             r_state;
  logic [3:0]         r_bit;
  logic [FRAME_W-1:0] r_shift;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_sclk;
  logic               r_copi;
  logic               r_ncs;

  logic               w_tick;
  logic               w_accept;
  logic               w_reject;
  logic               w_last_bit;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic [FRAME_W-1:0] w_frame;

  assign w_frame    = build_frame(req_addr, req_data);
  assign w_accept   = (r_state == ST_IDLE) && req_valid && (req_addr <= MAX_ADDR);
  assign w_reject   = (r_state == ST_IDLE) && req_valid && (req_addr > MAX_ADDR);
  assign w_last_bit = (r_bit == 4'(FRAME_W - 1));

  // Every phase boundary reloads the timer; only the final SHIFT_LO loads the gap length.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = C_DIV_LOAD;
    case (r_state)
      ST_IDLE:     w_load = w_accept;
      ST_SETUP,
      ST_SHIFT_HI: w_load = w_tick;
      ST_SHIFT_LO: begin
        w_load = w_tick;
        if (w_last_bit) begin
          w_load_val = C_GAP_LOAD;
        end
      end
      default:     w_load = 1'b0;
    endcase
  end

  spi_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= w_frame;
            r_copi  <= w_frame[WRITE_BIT];
            r_bit   <= '0;
            r_ncs   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_SETUP;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (w_tick) begin
            r_sclk  <= 1'b0;
            r_state <= ST_SHIFT_LO;
            // Rotate so the next bit sits at the MSB; after the last bit copi just holds.
            if (!w_last_bit) begin
              r_shift <= {r_shift[FRAME_W-2:0], r_shift[FRAME_W-1]};
              r_copi  <= r_shift[WRITE_BIT-1];
            end
          end
        end
        ST_SHIFT_LO: begin
          if (w_tick) begin
            if (w_last_bit) begin
              r_ncs   <= 1'b1;
              r_copi  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_sclk  <= 1'b1;
              r_state <= ST_SHIFT_HI;
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_sclk  <= 1'b0;
          r_copi  <= 1'b0;
          r_ncs   <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign sclk      = r_sclk;
  assign copi      = r_copi;
  assign ncs       = r_ncs;

endmodule
`default_nettype wire

// File: tb/tb_spi_write_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_write_sequencer                                                     |
// | Directed bench: default instance plus a CLK_DIV=3/NCS_GAP=3 instance.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_spi_write_sequencer;
  import spi_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic [6:0] req_addr  = '0;
  logic [7:0] req_data  = '0;
  logic       req_ready, busy, done, err, sclk, copi, ncs;

  logic       req_valid3 = 1'b0;
  logic [6:0] req_addr3  = '0;
  logic [7:0] req_data3  = '0;
  logic       req_ready3, busy3, done3, err3, sclk3, copi3, ncs3;

  spi_write_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .done(done), .err(err),
    .sclk(sclk), .copi(copi), .ncs(ncs)
  );

  spi_write_sequencer #(.CLK_DIV(3), .NCS_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_addr(req_addr3), .req_data(req_data3),
    .req_ready(req_ready3), .busy(busy3), .done(done3), .err(err3),
    .sclk(sclk3), .copi(copi3), .ncs(ncs3)
  );

  logic sel = 1'b0;
  logic m_ready, m_ncs, m_sclk, m_copi, m_done, m_err;
  assign m_ready = sel ? req_ready3 : req_ready;
  assign m_ncs   = sel ? ncs3       : ncs;
  assign m_sclk  = sel ? sclk3      : sclk;
  assign m_copi  = sel ? copi3      : copi;
  assign m_done  = sel ? done3      : done;
  assign m_err   = sel ? err3       : err;

  int total = 0;
  int bad   = 0;
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) begin
      acc_cyc <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Register-port model of the default instance's SPI slave.
  logic [7:0]  regs [0:4] = '{default: 8'h00};
  logic [15:0] mdl_sh = '0;
  int          mdl_n = 0;
  logic        p_sclk = 1'b0, p_ncs = 1'b1;
  always @(posedge clk) begin
    p_sclk <= sclk;
    p_ncs  <= ncs;
    if (p_ncs && !ncs) begin
      mdl_n <= 0;
    end else if (!ncs && sclk && !p_sclk) begin
      mdl_sh <= {mdl_sh[14:0], copi};
      mdl_n  <= mdl_n + 1;
    end
    if (ncs && !p_ncs && mdl_n == 16 && mdl_sh[15] && mdl_sh[14:8] <= 7'd4)
      regs[mdl_sh[10:8]] <= mdl_sh[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic s, input logic [6:0] a, input logic [7:0] d, input bit hold);
    sel = s;
    @(negedge clk);
    if (!s) begin req_valid = 1'b1; req_addr = a; req_data = d; end
    else    begin req_valid3 = 1'b1; req_addr3 = a; req_data3 = d; end
    for (int k = 0; k < 400 && !m_ready; k++) @(negedge clk);
    chk("wait_ready", m_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid  = 1'b0;
      req_valid3 = 1'b0;
    end
  endtask

  int          ms_ncs_low, ms_first, ms_rises, ms_ready, ms_viol, ms_done_n, ms_done_idx, ms_err_n;
  logic [15:0] ms_word;

  // Samples on negedges; index 0 is the first sample after the accepting edge.
  task automatic measure(input int d);
    logic ps, pc;
    bit   up;
    int   last;
    ms_ncs_low = -1; ms_first = -1; ms_rises = 0; ms_ready = -1; ms_viol = 0;
    ms_done_n = 0; ms_done_idx = -1; ms_err_n = 0; ms_word = '0;
    ps = 1'b0; pc = 1'b0; up = 1'b0; last = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 0) pc = m_copi;
      if (m_copi !== pc && m_sclk) ms_viol++;
      if (m_sclk && m_ncs) ms_viol++;
      if (m_sclk && !ps) begin
        if (ms_rises == 0) ms_first = i;
        else if (i - last != 2 * d) ms_viol++;
        last = i;
        ms_rises++;
        ms_word = {ms_word[14:0], m_copi};
      end
      if (m_ncs && !up) begin up = 1'b1; ms_ncs_low = i; end
      if (up && !m_ncs) ms_viol++;
      if (m_done) begin ms_done_n++; ms_done_idx = i; end
      if (m_err) ms_err_n++;
      if (m_ready) begin ms_ready = i; break; end
      ps = m_sclk;
      pc = m_copi;
    end
  endtask

  task automatic chk_frame(input string t, input int d, input int g, input logic [15:0] word);
    chk({t, ".copi_word"}, ms_word, word);
    chk({t, ".ncs_low"}, ms_ncs_low, 33 * d);
    chk({t, ".first_rise"}, ms_first, d);
    chk({t, ".rises"}, ms_rises, 16);
    chk({t, ".violations"}, ms_viol, 0);
    chk({t, ".done_count"}, ms_done_n, 1);
    chk({t, ".done_at"}, ms_done_idx, 33 * d);
    chk({t, ".ready_at"}, ms_ready, 33 * d + g);
    chk({t, ".err_count"}, ms_err_n, 0);
  endtask

  logic [7:0] exp_regs [0:4] = '{default: 8'h00};
  int c1, dc0, n;
  logic ps;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.ncs", ncs, 1);
    chk("rst.sclk", sclk, 0);
    chk("rst.copi", copi, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.ready", req_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write, addr 2 / 0xA5
    do_write(1'b0, 7'd2, 8'hA5, 1'b0);
    measure(4);
    chk_frame("t1", 4, 4, 16'h82A5);
    exp_regs[2] = 8'hA5;

    // Back-to-back requests held continuously
    do_write(1'b0, 7'd0, 8'hFF, 1'b1);
    c1 = acc_cyc;
    req_addr = 7'd4;
    req_data = 8'h80;
    measure(4);
    chk_frame("t2a", 4, 4, 16'h80FF);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t2.accept_spacing", acc_cyc - c1, 137);
    measure(4);
    chk_frame("t2b", 4, 4, 16'h8480);
    exp_regs[0] = 8'hFF;
    exp_regs[4] = 8'h80;

    // Invalid address, then a legal one on the very next cycle
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'd5; req_data = 8'h11;
    @(posedge clk);
    #1;
    c1 = acc_cyc;
    req_addr = 7'd4; req_data = 8'h3C;
    @(negedge clk);
    chk("t3.err", err, 1);
    chk("t3.ready", req_ready, 1);
    chk("t3.ncs", ncs, 1);
    chk("t3.sclk", sclk, 0);
    chk("t3.busy", busy, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t3.accept_next", acc_cyc - c1, 1);
    measure(4);
    chk_frame("t3", 4, 4, 16'h843C);
    exp_regs[4] = 8'h3C;

    // Reset after the 7th SCLK rise
    dc0 = done_cnt;
    do_write(1'b0, 7'd1, 8'h55, 1'b0);
    n = 0; ps = 1'b0;
    for (int k = 0; k < 300 && n < 7; k++) begin
      @(negedge clk);
      if (sclk && !ps) n++;
      ps = sclk;
    end
    chk("t4.rises_before_rst", n, 7);
    #2 rst = 1'b1;
    #1;
    chk("t4.ncs", ncs, 1);
    chk("t4.sclk", sclk, 0);
    chk("t4.copi", copi, 0);
    chk("t4.busy", busy, 0);
    chk("t4.ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4.no_done", done_cnt, dc0);
    chk("t4.reg1_untouched", regs[1], exp_regs[1]);
    do_write(1'b0, 7'd1, 8'h55, 1'b0);
    measure(4);
    chk_frame("t4b", 4, 4, 16'h8155);
    exp_regs[1] = 8'h55;

    // CLK_DIV=3, NCS_GAP=3 instance
    do_write(1'b1, 7'd2, 8'h5A, 1'b0);
    measure(3);
    chk_frame("t5", 3, 3, 16'h825A);

    // End-to-end through the register model
    do_write(1'b0, 7'd4, 8'h7F, 1'b0);
    measure(4);
    chk_frame("t6a", 4, 4, 16'h847F);
    repeat (3) @(negedge clk);
    exp_regs[4] = 8'h7F;
    chk("t6.duty", regs[4], 8'h7F);
    do_write(1'b0, 7'd3, 8'hC3, 1'b0);
    measure(4);
    chk_frame("t6b", 4, 4, 16'h83C3);
    repeat (3) @(negedge clk);
    exp_regs[3] = 8'hC3;
    for (int i = 0; i < 5; i++) chk($sformatf("t6.reg%0d", i), regs[i], exp_regs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
